// File: rtl/rv_hazard_ctrl.sv
// rv_hazard_ctrl: pipeline hazard and control unit for the 5-stage RV core.
// Produces operand bypass selects, load-use interlocks, memory-wait freeze,
// multi-cycle execute wait with watchdog, post-reset flush and a sticky
// illegal-instruction trap released by an explicit acknowledge.
module rv_hazard_ctrl #(
  parameter int BP_SRC     = 3,
  parameter int RST_FLUSH  = 2,
  parameter int MC_TIMEOUT = 64,
  parameter int SELW       = $clog2(BP_SRC + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [4:0]            i_decode_rs1,
  input  logic [4:0]            i_decode_rs2,
  input  logic                  i_decode_inv_instr,
  input  logic [4:0]            i_exec_rs1,
  input  logic [4:0]            i_exec_rs2,
  input  logic [4:0]            i_exec_rd,
  input  logic                  i_exec_is_load,
  input  logic                  i_exec_pc_sel,
  input  logic                  i_exec_mc_start,
  input  logic                  i_mc_done,
  input  logic                  i_mem_wait,
  input  logic [BP_SRC-1:0]     i_bp_we,
  input  logic [5*BP_SRC-1:0]   i_bp_rd,
  input  logic                  i_trap_ack,
  output logic [SELW-1:0]       o_exec_bp_rs1,
  output logic [SELW-1:0]       o_exec_bp_rs2,
  output logic                  o_fetch_stall,
  output logic                  o_decode_stall,
  output logic                  o_exec_stall,
  output logic                  o_mem_stall,
  output logic                  o_decode_flush,
  output logic                  o_exec_flush,
  output logic                  o_trap,
  output logic                  o_mc_timeout
);

  localparam int FCW = $clog2(RST_FLUSH + 1);
  localparam int WDW = $clog2(MC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RST     = 2'd0,
    ST_RUN     = 2'd1,
    ST_MC_WAIT = 2'd2,
    ST_TRAP    = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [FCW-1:0]   flush_cnt_reg, flush_cnt_next;
  logic [WDW-1:0]   wdog_reg, wdog_next;

  logic [BP_SRC-1:0] hit_rs1, hit_rs2;
  logic [SELW-1:0]   sel_rs1, sel_rs2;
  logic              load_use;

  // Per-source match: source writes, operand is not x0, and register numbers agree.
  for (genvar gi = 0; gi < BP_SRC; gi++) begin : g_bp_hit
    assign hit_rs1[gi] = i_bp_we[gi] && (i_exec_rs1 != 5'd0) && (i_exec_rs1 == i_bp_rd[5*gi +: 5]);
    assign hit_rs2[gi] = i_bp_we[gi] && (i_exec_rs2 != 5'd0) && (i_exec_rs2 == i_bp_rd[5*gi +: 5]);
  end

  // Priority select: nearest (lowest index) matching source wins.
  always_comb begin
    sel_rs1 = '0;
    sel_rs2 = '0;
    for (int k = BP_SRC - 1; k >= 0; k--) begin
      if (hit_rs1[k]) sel_rs1 = SELW'(k + 1);
      if (hit_rs2[k]) sel_rs2 = SELW'(k + 1);
    end
  end

  assign load_use = i_exec_is_load && (i_exec_rd != 5'd0) &&
                    ((i_decode_rs1 == i_exec_rd) || (i_decode_rs2 == i_exec_rd));

  // Next-state and combinational stall/flush/bypass decode from current state and inputs.
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    wdog_next      = wdog_reg;
    o_exec_bp_rs1  = sel_rs1;
    o_exec_bp_rs2  = sel_rs2;
    o_fetch_stall  = 1'b0;
    o_decode_stall = 1'b0;
    o_exec_stall   = 1'b0;
    o_mem_stall    = 1'b0;
    o_decode_flush = 1'b0;
    o_exec_flush   = 1'b0;
    o_trap         = 1'b0;
    o_mc_timeout   = 1'b0;

    case (state_reg)
      ST_RST: begin
        o_exec_bp_rs1  = '0;
        o_exec_bp_rs2  = '0;
        o_decode_flush = 1'b1;
        o_exec_flush   = 1'b1;
        flush_cnt_next = flush_cnt_reg - 1'b1;
        if (flush_cnt_reg <= FCW'(1)) state_next = ST_RUN;
      end

      ST_RUN: begin
        if (i_mem_wait) begin
          // Whole pipe frozen; any redirect or mc launch in execute simply waits.
          o_fetch_stall  = 1'b1;
          o_decode_stall = 1'b1;
          o_exec_stall   = 1'b1;
          o_mem_stall    = 1'b1;
        end else if (i_exec_pc_sel) begin
          o_decode_flush = 1'b1;
          o_exec_flush   = 1'b1;
        end else if (i_exec_mc_start) begin
          o_fetch_stall  = 1'b1;
          o_decode_stall = 1'b1;
          o_exec_stall   = 1'b1;
          state_next     = ST_MC_WAIT;
          wdog_next      = WDW'(1);
        end else if (load_use) begin
          o_fetch_stall  = 1'b1;
          o_decode_stall = 1'b1;
          o_exec_flush   = 1'b1;
        end else if (i_decode_inv_instr) begin
          state_next = ST_TRAP;
        end
      end

      ST_MC_WAIT: begin
        o_fetch_stall  = 1'b1;
        o_decode_stall = 1'b1;
        o_exec_stall   = 1'b1;
        o_mem_stall    = i_mem_wait;
        if (i_mc_done) begin
          // Result arrives: release execute in this same cycle (done beats expiry).
          o_fetch_stall  = 1'b0;
          o_decode_stall = 1'b0;
          o_exec_stall   = 1'b0;
          state_next     = ST_RUN;
        end else if (wdog_reg == WDW'(MC_TIMEOUT)) begin
          o_mc_timeout = 1'b1;
          state_next   = ST_TRAP;
        end else begin
          wdog_next = wdog_reg + 1'b1;
        end
      end

      ST_TRAP: begin
        o_fetch_stall  = 1'b1;
        o_decode_flush = 1'b1;
        o_exec_flush   = 1'b1;
        o_trap         = 1'b1;
        o_mem_stall    = i_mem_wait;
        if (i_trap_ack) state_next = ST_RUN;
      end

      default: state_next = ST_RST;
    endcase
  end

  // State registers; reset aborts any state and reloads the flush counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_reg     <= ST_RST;
      flush_cnt_reg <= FCW'(RST_FLUSH);
      wdog_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      wdog_reg      <= wdog_next;
    end
  end

endmodule
